// File: rtl/mem_access_unit.sv
// Sequences fetch/LW/SW accesses from the multi-cycle controller onto a slow req/ack memory port.
// Optional single-entry read buffer enabled by defining MEM_RD_BUF_EN.
//
// state | meaning
// IDLE  | no access in flight; a request raises stall and is launched at the edge
// WAIT  | mem_req held, counting cycles until mem_ack or timeout
// RESP  | access done; stall low so the controller advances
// ERR   | memory never answered; stuck until rst
module mem_access_unit #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic          wr_req,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          bus_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

  state_t        state;
  logic [7:0]    wait_cnt;
  logic          req;
  logic [AW-1:0] word_addr;
  logic          buf_hit;
  logic          addr_lsb_unused;

  assign req       = rd_req | wr_req;
  assign word_addr = {addr[AW-1:2], 2'b00};
  // Only word accesses exist; the byte offset is intentionally dropped.
  assign addr_lsb_unused = ^addr[1:0];

  assign stall = (state == WAIT) || (state == ERR) || ((state == IDLE) && req);

`ifdef MEM_RD_BUF_EN
  logic          buf_valid;
  logic [AW-1:2] buf_tag;
  logic [DW-1:0] buf_data;

  assign buf_hit = rd_req && !wr_req && buf_valid && (buf_tag == addr[AW-1:2]);
`else
  assign buf_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
`ifdef MEM_RD_BUF_EN
      buf_valid   <= 1'b0;
      buf_tag     <= '0;
      buf_data    <= '0;
`endif
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (buf_hit) begin
`ifdef MEM_RD_BUF_EN
            rdata <= buf_data;
`endif
            rdata_valid <= 1'b1;
            state       <= RESP;
          end else if (req) begin
            // Write wins when both requests are raised together.
            mem_we    <= wr_req;
            mem_addr  <= word_addr;
            mem_wdata <= wdata;
            mem_req   <= 1'b1;
            wait_cnt  <= 8'd0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (mem_ack) begin
            mem_req  <= 1'b0;
            wait_cnt <= 8'd0;
            state    <= RESP;
            if (!mem_we) begin
              rdata       <= mem_rdata;
              rdata_valid <= 1'b1;
`ifdef MEM_RD_BUF_EN
              buf_valid   <= 1'b1;
              buf_tag     <= mem_addr[AW-1:2];
              buf_data    <= mem_rdata;
            end else if (buf_valid && (buf_tag == mem_addr[AW-1:2])) begin
              buf_data <= mem_wdata;
`endif
            end
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= ERR;
          end
        end
        RESP: state <= IDLE;
        ERR:  state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: access-level reference model plus directed vectors.
// Buffer-specific expectations follow MEM_RD_BUF_EN, matching the DUT build.
module tb_mem_access_unit;

  localparam int TIMEOUT = 15;
`ifdef MEM_RD_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk, rst, rd_req, wr_req, mem_ack;
  logic [31:0] addr, wdata, mem_rdata;
  logic        stall, rdata_valid, bus_err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;

  mem_access_unit #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the access in flight as "busy / responding / dead".
  bit          m_busy, m_resp, m_err;
  int          m_waits;
  logic        e_req, e_we, e_valid, e_err;
  logic [31:0] e_addr, e_wdata, e_rdata;
  bit          mb_valid;
  logic [31:0] mb_addr, mb_data;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_resp = 0; m_err = 0; m_waits = 0;
      e_req = 0; e_we = 0; e_valid = 0; e_err = 0;
      e_addr = 0; e_wdata = 0; e_rdata = 0; mb_valid = 0;
    end else if (m_err) begin
      e_valid = 0;
    end else if (m_resp) begin
      m_resp = 0;
      e_valid = 0;
    end else if (m_busy) begin
      m_waits++;
      if (mem_ack) begin
        m_busy = 0; m_resp = 1; e_req = 0;
        if (!e_we) begin
          e_rdata = mem_rdata; e_valid = 1;
          mb_valid = 1; mb_addr = e_addr; mb_data = mem_rdata;
        end else if (mb_valid && mb_addr == e_addr) begin
          mb_data = e_wdata;
        end
      end else if (m_waits == TIMEOUT) begin
        m_busy = 0; m_err = 1; e_req = 0; e_err = 1;
      end
    end else if (rd_req || wr_req) begin
      if (BUF_EN && rd_req && !wr_req && mb_valid && mb_addr == (addr & 32'hFFFF_FFFC)) begin
        m_resp = 1; e_rdata = mb_data; e_valid = 1;
      end else begin
        m_busy = 1; m_waits = 0; e_req = 1; e_we = wr_req;
        e_addr = addr & 32'hFFFF_FFFC; e_wdata = wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("stall", 32'(stall), 32'(m_err || m_busy || (!m_resp && (rd_req || wr_req))));
      check("mem_req", 32'(mem_req), 32'(e_req));
      check("bus_err", 32'(bus_err), 32'(e_err));
      check("rdata_valid", 32'(rdata_valid), 32'(e_valid));
      check("rdata", rdata, e_rdata);
      if (e_req) begin
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  // Results of the most recent access() call.
  int          t_lat, t_req;
  logic        t_stall0, t_we, t_valid;
  logic [31:0] t_addr, t_wdata, t_rdata;

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int ack_after, input logic [31:0] rdd, input int max_cyc);
    int waits = 0;
    rd_req = rd; wr_req = wr; addr = a; wdata = d;
    t_lat = max_cyc; t_req = 0; t_we = 0; t_addr = 0; t_wdata = 0;
    #1 t_stall0 = stall;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!stall) begin
        t_lat = c;
        break;
      end
      if (mem_req) begin
        t_req++; t_addr = mem_addr; t_we = mem_we; t_wdata = mem_wdata;
        waits++;
        if (waits == ack_after) begin
          mem_ack = 1'b1; mem_rdata = rdd;
        end
      end
    end
    t_rdata = rdata; t_valid = rdata_valid;
    rd_req = 1'b0; wr_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    rst = 1'b1; rd_req = 0; wr_req = 0; addr = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    check("rst stall", 32'(stall), 0);
    check("rst rdata", rdata, 0);
    check("rst rdata_valid", 32'(rdata_valid), 0);
    check("rst bus_err", 32'(bus_err), 0);
    check("rst mem_req", 32'(mem_req), 0);
    check("rst mem_we", 32'(mem_we), 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);

    // Read 0x10, ack in first WAIT cycle.
    access(1, 0, 32'h0000_0010, 0, 1, 32'hDEAD_BEEF, 20);
    check("rd stall cyc0", 32'(t_stall0), 1);
    check("rd latency", 32'(t_lat), 2);
    check("rd req cycles", 32'(t_req), 1);
    check("rd mem_addr", t_addr, 32'h10);
    check("rd mem_we", 32'(t_we), 0);
    check("rd rdata", t_rdata, 32'hDEAD_BEEF);
    check("rd valid", 32'(t_valid), 1);

    // Write 0x23, ack after 4 WAIT cycles.
    access(0, 1, 32'h0000_0023, 32'h1234_5678, 4, 32'hFFFF_FFFF, 20);
    check("wr latency", 32'(t_lat), 5);
    check("wr req cycles", 32'(t_req), 4);
    check("wr mem_addr", t_addr, 32'h20);
    check("wr mem_we", 32'(t_we), 1);
    check("wr mem_wdata", t_wdata, 32'h1234_5678);
    check("wr no valid", 32'(t_valid), 0);
    check("wr rdata held", t_rdata, 32'hDEAD_BEEF);

    // Simultaneous read and write: write wins.
    access(1, 1, 32'h0000_0030, 32'hCAFE_F00D, 2, 32'h1111_1111, 20);
    check("both we", 32'(t_we), 1);
    check("both addr", t_addr, 32'h30);
    check("both latency", 32'(t_lat), 3);
    check("both no valid", 32'(t_valid), 0);
    check("both rdata held", t_rdata, 32'hDEAD_BEEF);

    // Reset in the 2nd WAIT cycle, then a late ack.
    rd_req = 1; addr = 32'h50;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst req before", 32'(mem_req), 1);
    rst = 1; rd_req = 0;
    @(posedge clk); #1;
    rst = 0;
    check("midrst mem_req", 32'(mem_req), 0);
    check("midrst stall", 32'(stall), 0);
    check("midrst rdata", rdata, 0);
    mem_ack = 1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    mem_ack = 0;
    check("late ack rdata", rdata, 0);
    check("late ack valid", 32'(rdata_valid), 0);
    check("late ack mem_req", 32'(mem_req), 0);

    // Read buffer sequence (hits only when the buffer is built in).
    access(1, 0, 32'h40, 0, 1, 32'hA5A5_A5A5, 20);
    check("buf fill rdata", t_rdata, 32'hA5A5_A5A5);
    check("buf fill latency", 32'(t_lat), 2);
    access(1, 0, 32'h42, 0, 1, 32'h0BAD_0BAD, 20);
    check("reread req cycles", 32'(t_req), BUF_EN ? 0 : 1);
    check("reread latency", 32'(t_lat), BUF_EN ? 1 : 2);
    check("reread rdata", t_rdata, BUF_EN ? 32'hA5A5_A5A5 : 32'h0BAD_0BAD);
    access(0, 1, 32'h40, 32'h1, 1, 0, 20);
    access(0, 1, 32'h48, 32'h7, 1, 0, 20);
    check("other wr addr", t_addr, 32'h48);
    access(1, 0, 32'h40, 0, 1, 32'h2222_2222, 20);
    check("post-wr req cycles", 32'(t_req), BUF_EN ? 0 : 1);
    check("post-wr rdata", t_rdata, BUF_EN ? 32'h1 : 32'h2222_2222);
    check("post-wr valid", 32'(t_valid), 1);

    // No ack: timeout after TIMEOUT WAIT cycles.
    access(1, 0, 32'h80, 0, 0, 0, 20);
    check("to req cycles", 32'(t_req), 15);
    check("to never released", 32'(t_lat), 20);
    check("to bus_err", 32'(bus_err), 1);
    check("to mem_req", 32'(mem_req), 0);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!stall || mem_req) lows++;
    end
    check("err held 50 cycles", 32'(lows), 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("err rst stall", 32'(stall), 0);
    check("err rst bus_err", 32'(bus_err), 0);
    check("err rst rdata", rdata, 0);
    check("err rst mem_req", 32'(mem_req), 0);
    check("err rst mem_addr", mem_addr, 0);
    check("err rst mem_wdata", mem_wdata, 0);
    check("err rst mem_we", 32'(mem_we), 0);
    @(posedge clk); #1;

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequences every access from the multi-cycle core controller to a slow unified instruction/data memory.
- Covers instruction fetch, LW and SW, using a req/ack handshake toward memory.
- Raises a stall back to the controller so it holds its current state until the access completes.
- Sits directly between the controller/datapath address mux and the memory port.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- TIMEOUT, 15, maximum number of WAIT cycles without mem_ack before a bus error is declared (legal range 2..255).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- rd_req  in  1  read request from controller (fetch or LW); held stable while stall=1.
- wr_req  in  1  write request from controller (SW); held stable while stall=1.
- addr  in  AW  byte address from the datapath address mux.
- wdata  in  DW  store data.
- stall  out  1  controller must not advance state while high.
- rdata  out  DW  read data, registered, held until the next completed read.
- rdata_valid  out  1  one-cycle pulse when rdata has just been updated.
- bus_err  out  1  sticky timeout error.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  AW  word-aligned address.
- mem_wdata  out  DW  write data.
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  DW  read data; valid in the mem_ack cycle.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, timeout counter=0. All outputs are 0: stall, rdata, rdata_valid, bus_err, mem_req, mem_we, mem_addr, mem_wdata.
- The FSM has four states: IDLE, WAIT, RESP, ERR.
- IDLE:
  - When rd_req|wr_req=1, stall=1 combinationally in the same cycle.
  - At the edge: latch we=wr_req, mem_addr={addr[AW-1:2],2'b00}, mem_wdata=wdata; set mem_req=1; go WAIT.
  - If rd_req and wr_req are both 1, the write wins and the read is dropped (no error).
- WAIT:
  - mem_req=1 and stall=1. Address, data and we are held constant.
  - Counter increments every WAIT cycle.
  - If mem_ack=1: mem_req drops at the edge; reads load rdata<=mem_rdata; go RESP; counter clears.
  - If mem_ack=0 and counter==TIMEOUT-1: mem_req drops, bus_err<=1, go ERR.
- RESP:
  - stall=0, so the controller advances at this edge.
  - rdata_valid=1 for exactly this cycle, and only for reads.
  - Always go IDLE next. Requests present during RESP are not accepted; they are taken up in IDLE on the next cycle.
- ERR: stall=1 and mem_req=0 permanently. Only rst exits ERR.
- Latency: request seen in cycle 0 (IDLE), ack in cycle 1 (WAIT), stall low in cycle 2 (RESP). The minimum is 3 cycles per access; each extra ack-wait cycle adds 1.
- mem_ack outside WAIT is ignored.
- rst asserted mid-access: at that edge go IDLE, clear everything including bus_err. The pending access is abandoned and mem_req is 0 from the next cycle.
- The addr[1:0] byte offset is discarded; only word accesses are supported.

Optional Feature:
- Macro: MEM_RD_BUF_EN.
- Defined:
  - Adds a single-entry read buffer (tag = word address, data, valid bit), cleared by rst.
  - A read in IDLE whose word address matches a valid tag skips WAIT. IDLE goes to RESP with rdata<=buffer data and mem_req never asserted, giving 2-cycle latency.
  - Every completed memory read fills the buffer.
  - A write to the tagged address updates the buffer data; a write to any other address leaves the buffer unchanged.
- Undefined: no buffer; every access goes to memory as described in Behaviour.

Test Plan:
- Read at addr=0x0000_0010, mem_ack in 1st WAIT cycle with mem_rdata=0xDEAD_BEEF: mem_addr=0x10, mem_we=0; stall high for cycles 0-1 and low in cycle 2; rdata=0xDEAD_BEEF with rdata_valid pulse in cycle 2.
- Write addr=0x0000_0023, wdata=0x1234_5678, ack after 4 wait cycles: mem_addr=0x20, mem_we=1, mem_wdata=0x1234_5678 held 4 cycles; no rdata_valid; stall released exactly one cycle after ack.
- No ack with TIMEOUT=15: bus_err=1 after 15 WAIT cycles; mem_req=0; stall stays 1 for 50 further cycles; rst clears all outputs to 0.
- rd_req=wr_req=1 together: write performed (mem_we=1); no read occurs.
- rst pulsed during the 2nd WAIT cycle: next cycle mem_req=0 and state IDLE; a late mem_ack is ignored; rdata=0.
- With MEM_RD_BUF_EN: read 0x40 (ack data 0xA5A5_A5A5), then read 0x40 again: second read has no mem_req, rdata_valid in cycle 1. Then write 0x40=0x1 and read 0x40: returns 0x1 with no mem_req.
